// File: rtl/cache_controller_nway_pkg.sv
// Shared definitions for the n-way write-back cache controller.
package cache_controller_nway_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_HIT    = 3'd2,
    S_WB     = 3'd3,
    S_FILL   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  localparam int unsigned DEF_ADDR_WIDTH  = 16;
  localparam int unsigned DEF_INDEX_SIZE  = 3;
  localparam int unsigned DEF_OFFSET_SIZE = 5;

  function automatic int unsigned tag_size(input int unsigned aw, input int unsigned iw,
                                           input int unsigned ow);
    return aw - iw - ow;
  endfunction

  function automatic int unsigned way_bits(input int unsigned ways);
    return (ways == 2) ? 1 : 0;
  endfunction

endpackage

// File: rtl/cache_controller_nway_tag_store.sv
// Tag/valid/dirty/LRU storage with combinational compare against the addressed set.
module cache_tag_store
  import cache_controller_nway_pkg::*;
#(
  parameter int unsigned TAG_SIZE   = 8,
  parameter int unsigned INDEX_SIZE = 3,
  parameter int unsigned WAYS       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_SIZE-1:0] index,
  input  logic [TAG_SIZE-1:0]   tag,
  output logic                  hit,
  output logic                  hit_way,
  output logic                  victim_way,
  output logic                  victim_dirty,
  output logic [TAG_SIZE-1:0]   victim_tag,
  input  logic                  acc_en,
  input  logic                  acc_way,
  input  logic                  acc_wr,
  input  logic                  clean_en,
  input  logic                  fill_en,
  input  logic                  fill_way
);

  localparam int unsigned SETS = 2 ** INDEX_SIZE;

  logic [TAG_SIZE-1:0] tags  [WAYS][SETS];
  logic [SETS-1:0]     valid [WAYS];
  logic [SETS-1:0]     dirty [WAYS];
  logic                lru_way;
  logic                found;

  // Line state: fill installs a clean line, writeback cleans, CPU write dirties.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        valid[w] <= '0;
        dirty[w] <= '0;
      end
    end else begin
      if (fill_en) begin
        valid[fill_way][index] <= 1'b1;
        dirty[fill_way][index] <= 1'b0;
      end
      if (clean_en) dirty[fill_way][index] <= 1'b0;
      if (acc_en && acc_wr) dirty[acc_way][index] <= 1'b1;
    end
  end

  // Tag array needs no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_en) tags[fill_way][index] <= tag;
  end

  if (WAYS == 2) begin : g_lru
    logic [SETS-1:0] lru;
    // LRU bit names the way to evict next: the one not just accessed.
    always_ff @(posedge clk) begin
      if (rst) lru <= '0;
      else if (acc_en) lru[index] <= ~acc_way;
    end
    assign lru_way = lru[index];
  end else begin : g_no_lru
    assign lru_way = 1'b0;
  end

  // Hit search plus victim choice: lowest invalid way, else the LRU way.
  always_comb begin
    hit        = 1'b0;
    hit_way    = 1'b0;
    victim_way = lru_way;
    found      = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && valid[w][index] && (tags[w][index] == tag)) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
      if (!found && !valid[w][index]) begin
        found      = 1'b1;
        victim_way = 1'(w);
      end
    end
  end

  assign victim_dirty = valid[victim_way][index] & dirty[victim_way][index];
  assign victim_tag   = tags[victim_way][index];

endmodule

// File: rtl/cache_controller_nway.sv
// Write-back cache controller between CPU request port and SDRAM burst port.
module cache_controller_nway
  import cache_controller_nway_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned INDEX_SIZE  = DEF_INDEX_SIZE,
  parameter int unsigned OFFSET_SIZE = DEF_OFFSET_SIZE,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned CS_WAIT     = 4,
  parameter int unsigned SDRAM_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] Address_cpu,
  input  logic                  wr_rd_cpu,
  input  logic                  cs_cpu,
  output logic                  rdy_cpu,
  output logic [ADDR_WIDTH-1:0] Address_sdram,
  output logic                  wr_rd_sdram,
  output logic                  mstrb_sdram,
  output logic                  mux_sel,
  output logic                  demux_sel,
  output logic                  wen_sram,
  output logic [way_bits(WAYS)+INDEX_SIZE+OFFSET_SIZE-1:0] address_sram,
  output logic [2:0]            current_state
);

  localparam int unsigned TAG_SIZE = tag_size(ADDR_WIDTH, INDEX_SIZE, OFFSET_SIZE);
  localparam int unsigned SRAM_W   = way_bits(WAYS) + INDEX_SIZE + OFFSET_SIZE;
  localparam int unsigned CS_W     = $clog2(CS_WAIT + 1);
  localparam int unsigned LAT_W    = (SDRAM_LAT > 0) ? $clog2(SDRAM_LAT + 1) : 1;

  state_t                 state;
  logic [CS_W-1:0]        cs_cnt;
  logic [OFFSET_SIZE-1:0] beat, next_beat;
  logic [LAT_W-1:0]       lat_cnt;
  logic [TAG_SIZE-1:0]    req_tag, vic_tag;
  logic [INDEX_SIZE-1:0]  req_index;
  logic [OFFSET_SIZE-1:0] req_offset;
  logic                   req_wr, way_q;
  logic                   beat_end, last_beat;
  logic                   hit, hit_way, victim_way, victim_dirty;
  logic [TAG_SIZE-1:0]    victim_tag;

  // Way bit is dropped by the cast when the cache is direct-mapped.
  function automatic logic [SRAM_W-1:0] sram_addr(input logic way,
      input logic [INDEX_SIZE-1:0] idx, input logic [OFFSET_SIZE-1:0] off);
    return SRAM_W'({way, idx, off});
  endfunction

  assign next_beat     = beat + 1'b1;
  assign beat_end      = (lat_cnt == LAT_W'(SDRAM_LAT));
  assign last_beat     = (beat == '1);
  assign current_state = state;

  cache_tag_store #(
    .TAG_SIZE  (TAG_SIZE),
    .INDEX_SIZE(INDEX_SIZE),
    .WAYS      (WAYS)
  ) u_tags (
    .clk         (clk),
    .rst         (rst),
    .index       (req_index),
    .tag         (req_tag),
    .hit         (hit),
    .hit_way     (hit_way),
    .victim_way  (victim_way),
    .victim_dirty(victim_dirty),
    .victim_tag  (victim_tag),
    .acc_en      (state == S_HIT),
    .acc_way     (way_q),
    .acc_wr      (req_wr),
    .clean_en    ((state == S_WB) && beat_end && last_beat),
    .fill_en     ((state == S_FILL) && beat_end && last_beat),
    .fill_way    (way_q)
  );

  // Control FSM; outputs are registered on entry to the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      rdy_cpu       <= 1'b1;
      Address_sdram <= '0;
      wr_rd_sdram   <= RD;
      mstrb_sdram   <= 1'b0;
      mux_sel       <= 1'b0;
      demux_sel     <= 1'b0;
      wen_sram      <= 1'b0;
      address_sram  <= '0;
      cs_cnt        <= '0;
      beat          <= '0;
      lat_cnt       <= '0;
      req_tag       <= '0;
      req_index     <= '0;
      req_offset    <= '0;
      req_wr        <= RD;
      vic_tag       <= '0;
      way_q         <= 1'b0;
    end else begin
      mstrb_sdram <= 1'b0;
      wen_sram    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!cs_cpu) begin
            cs_cnt <= '0;
          end else if (cs_cnt == CS_W'(CS_WAIT - 1)) begin
            cs_cnt     <= '0;
            req_tag    <= Address_cpu[ADDR_WIDTH-1 -: TAG_SIZE];
            req_index  <= Address_cpu[OFFSET_SIZE +: INDEX_SIZE];
            req_offset <= Address_cpu[OFFSET_SIZE-1:0];
            req_wr     <= wr_rd_cpu;
            rdy_cpu    <= 1'b0;
            state      <= S_LOOKUP;
          end else begin
            cs_cnt <= cs_cnt + 1'b1;
          end
        end
        S_LOOKUP: begin
          beat    <= '0;
          lat_cnt <= '0;
          if (hit) begin
            way_q        <= hit_way;
            address_sram <= sram_addr(hit_way, req_index, req_offset);
            wen_sram     <= req_wr;
            mux_sel      <= 1'b0;
            demux_sel    <= 1'b0;
            state        <= S_HIT;
          end else begin
            way_q        <= victim_way;
            mstrb_sdram  <= 1'b1;
            address_sram <= sram_addr(victim_way, req_index, {OFFSET_SIZE{1'b0}});
            if (victim_dirty) begin
              vic_tag       <= victim_tag;
              Address_sdram <= {victim_tag, req_index, {OFFSET_SIZE{1'b0}}};
              wr_rd_sdram   <= WR;
              demux_sel     <= 1'b1;
              mux_sel       <= 1'b0;
              state         <= S_WB;
            end else begin
              Address_sdram <= {req_tag, req_index, {OFFSET_SIZE{1'b0}}};
              wr_rd_sdram   <= RD;
              mux_sel       <= 1'b1;
              demux_sel     <= 1'b0;
              wen_sram      <= 1'b1;
              state         <= S_FILL;
            end
          end
        end
        S_WB: begin
          if (!beat_end) begin
            lat_cnt <= lat_cnt + 1'b1;
          end else begin
            lat_cnt     <= '0;
            beat        <= next_beat;
            mstrb_sdram <= 1'b1;
            if (last_beat) begin
              // Writeback flows straight into the fill burst with no gap.
              Address_sdram <= {req_tag, req_index, {OFFSET_SIZE{1'b0}}};
              address_sram  <= sram_addr(way_q, req_index, {OFFSET_SIZE{1'b0}});
              wr_rd_sdram   <= RD;
              demux_sel     <= 1'b0;
              mux_sel       <= 1'b1;
              wen_sram      <= 1'b1;
              state         <= S_FILL;
            end else begin
              Address_sdram <= {vic_tag, req_index, next_beat};
              address_sram  <= sram_addr(way_q, req_index, next_beat);
            end
          end
        end
        S_FILL: begin
          if (!beat_end) begin
            lat_cnt <= lat_cnt + 1'b1;
          end else begin
            lat_cnt <= '0;
            beat    <= next_beat;
            if (last_beat) begin
              // Replay the original access on the freshly filled way.
              address_sram <= sram_addr(way_q, req_index, req_offset);
              wen_sram     <= req_wr;
              mux_sel      <= 1'b0;
              demux_sel    <= 1'b0;
              state        <= S_HIT;
            end else begin
              mstrb_sdram   <= 1'b1;
              wen_sram      <= 1'b1;
              Address_sdram <= {req_tag, req_index, next_beat};
              address_sram  <= sram_addr(way_q, req_index, next_beat);
            end
          end
        end
        S_HIT: begin
          rdy_cpu   <= 1'b1;
          mux_sel   <= 1'b0;
          demux_sel <= 1'b0;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (!cs_cpu) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller_nway.sv
// Self-checking bench for cache_controller_nway: 2-way/LAT=2 and 1-way/LAT=0 instances.
module tb_cache_controller_nway;

  localparam int CS_WAIT = 4;
  localparam int LINE    = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] a0, a1;
  logic        w0, w1, cs0, cs1;
  logic        rdy0, rdy1, wrs0, wrs1, ms0, ms1, mux0, mux1, dm0, dm1, wen0, wen1;
  logic [15:0] as0, as1;
  logic [8:0]  sr0;
  logic [7:0]  sr1;
  logic [2:0]  st0, st1;

  cache_controller_nway #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .INDEX_SIZE(3), .OFFSET_SIZE(5),
    .WAYS(2), .CS_WAIT(CS_WAIT), .SDRAM_LAT(2)
  ) dut0 (
    .clk(clk), .rst(rst), .Address_cpu(a0), .wr_rd_cpu(w0), .cs_cpu(cs0),
    .rdy_cpu(rdy0), .Address_sdram(as0), .wr_rd_sdram(wrs0), .mstrb_sdram(ms0),
    .mux_sel(mux0), .demux_sel(dm0), .wen_sram(wen0), .address_sram(sr0),
    .current_state(st0)
  );

  cache_controller_nway #(
    .ADDR_WIDTH(16), .DATA_WIDTH(8), .INDEX_SIZE(3), .OFFSET_SIZE(5),
    .WAYS(1), .CS_WAIT(CS_WAIT), .SDRAM_LAT(0)
  ) dut1 (
    .clk(clk), .rst(rst), .Address_cpu(a1), .wr_rd_cpu(w1), .cs_cpu(cs1),
    .rdy_cpu(rdy1), .Address_sdram(as1), .wr_rd_sdram(wrs1), .mstrb_sdram(ms1),
    .mux_sel(mux1), .demux_sel(dm1), .wen_sram(wen1), .address_sram(sr1),
    .current_state(st1)
  );

  // Observation view of whichever instance is being exercised.
  logic        sel;
  logic        o_rdy, o_wrs, o_ms, o_mux, o_dm, o_wen;
  logic [15:0] o_as;
  logic [8:0]  o_sr;
  logic [2:0]  o_st;
  always_comb begin
    o_rdy = sel ? rdy1 : rdy0;
    o_wrs = sel ? wrs1 : wrs0;
    o_ms  = sel ? ms1  : ms0;
    o_mux = sel ? mux1 : mux0;
    o_dm  = sel ? dm1  : dm0;
    o_wen = sel ? wen1 : wen0;
    o_as  = sel ? as1  : as0;
    o_sr  = sel ? {1'b0, sr1} : sr0;
    o_st  = sel ? st1  : st0;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Reference cache state per instance: [inst][set][way].
  bit         mv   [2][8][2];
  bit         md   [2][8][2];
  logic [7:0] mt   [2][8][2];
  bit         mlru [2][8];
  int         m_ways [2] = '{2, 1};
  int         m_lat  [2] = '{2, 0};

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 8; i++) begin
        mlru[s][i] = 1'b0;
        for (int w = 0; w < 2; w++) begin
          mv[s][i][w] = 1'b0;
          md[s][i][w] = 1'b0;
          mt[s][i][w] = '0;
        end
      end
  endtask

  task automatic set_cs(input int s, input logic v);
    if (s == 0) cs0 = v; else cs1 = v;
  endtask

  task automatic do_req(input int s, input logic [15:0] a, input logic w, input bit drop);
    logic [7:0]  tg, vt;
    logic [2:0]  ix;
    logic [4:0]  of;
    logic [8:0]  exp_sram, cpu_addr;
    logic [15:0] ex_a[$];
    bit          ex_w[$];
    bit          hit, wb, seen_low;
    int          wy, ways, lat, bl, exp_lat, limit, n, n_rdy;
    int          nstb, bad_stb, nfill, bad_fill, ncpu, bad_hold;
    tg = a[15:8]; ix = a[7:5]; of = a[4:0];
    ways = m_ways[s]; lat = m_lat[s]; bl = LINE * (1 + lat);
    hit = 1'b0; wy = 0; wb = 1'b0; vt = '0;
    for (int i = 0; i < ways; i++)
      if (mv[s][ix][i] && mt[s][ix][i] == tg) begin hit = 1'b1; wy = i; end
    if (!hit) begin
      wy = (ways == 2) ? int'(mlru[s][ix]) : 0;
      for (int i = ways - 1; i >= 0; i--) if (!mv[s][ix][i]) wy = i;
      wb = mv[s][ix][wy] && md[s][ix][wy];
      vt = mt[s][ix][wy];
      if (wb) for (int k = 0; k < LINE; k++) begin ex_a.push_back({vt, ix, 5'(k)}); ex_w.push_back(1'b1); end
      for (int k = 0; k < LINE; k++) begin ex_a.push_back({tg, ix, 5'(k)}); ex_w.push_back(1'b0); end
    end
    exp_lat  = hit ? 2 : (wb ? 2 * bl + 2 : bl + 2);
    exp_sram = (ways == 2) ? {wy[0], ix, of} : {1'b0, ix, of};
    limit    = CS_WAIT + 2 * bl + 20;

    sel = s[0];
    if (s == 0) begin a0 = a; w0 = w; end else begin a1 = a; w1 = w; end
    set_cs(s, 1'b1);
    n = 0; n_rdy = -1; seen_low = 1'b0;
    nstb = 0; bad_stb = 0; nfill = 0; bad_fill = 0; ncpu = 0; cpu_addr = '0;
    while (n_rdy < 0 && n < limit) begin
      @(negedge clk);
      n++;
      if (o_ms) begin
        if (nstb < ex_a.size()) begin
          if (o_as !== ex_a[nstb] || o_wrs !== ex_w[nstb] || o_dm !== ex_w[nstb] ||
              o_mux !== !ex_w[nstb] || n != CS_WAIT + 1 + nstb * (1 + lat))
            bad_stb++;
        end
        nstb++;
      end
      if (o_wen) begin
        if (o_mux) begin
          nfill++;
          if (!o_ms || o_wrs) bad_fill++;
        end else begin
          ncpu++;
          cpu_addr = o_sr;
        end
      end
      if (!o_rdy) seen_low = 1'b1;
      else if (seen_low) n_rdy = n;
      if (drop && seen_low) set_cs(s, 1'b0);
    end
    chk("latency", n_rdy - CS_WAIT, exp_lat);
    chk("strobe_count", nstb, ex_a.size());
    chk("strobe_content", bad_stb, 0);
    chk("fill_wen_count", nfill, hit ? 0 : LINE);
    chk("fill_wen_align", bad_fill, 0);
    chk("cpu_wen_count", ncpu, w ? 1 : 0);
    if (w) chk("cpu_wen_addr", cpu_addr, exp_sram);
    if (!drop) begin
      bad_hold = 0;
      repeat (6) begin
        @(negedge clk);
        if (!o_rdy || o_st != 3'd5 || o_ms) bad_hold++;
      end
      chk("done_hold_no_resample", bad_hold, 0);
    end
    set_cs(s, 1'b0);
    @(negedge clk);
    chk("back_to_idle", o_st, 0);

    if (!hit) begin
      mv[s][ix][wy] = 1'b1;
      mt[s][ix][wy] = tg;
      md[s][ix][wy] = 1'b0;
    end
    if (w) md[s][ix][wy] = 1'b1;
    if (ways == 2) mlru[s][ix] = (wy == 0);
  endtask

  initial begin
    int  bad;
    bit  found;
    rst = 1'b1; sel = 1'b0;
    a0 = '0; a1 = '0; w0 = 1'b0; w1 = 1'b0; cs0 = 1'b0; cs1 = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_rdy0", rdy0, 1);
    chk("reset_outputs0", {ms0, wrs0, mux0, dm0, wen0, sr0, st0}, 0);
    chk("reset_sdram_addr0", as0, 0);
    chk("reset_rdy1", rdy1, 1);
    chk("reset_outputs1", {ms1, wrs1, mux1, dm1, wen1, sr1, st1, as1}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed 2-way scenario: clean miss, write hit, second way, dirty eviction.
    do_req(0, 16'h1234, 1'b0, 1'b0);
    do_req(0, 16'h1234, 1'b1, 1'b0);
    do_req(0, 16'h5634, 1'b0, 1'b0);
    do_req(0, 16'h9A34, 1'b0, 1'b0);

    // Request held one cycle short of the sampling window.
    sel = 1'b0; a0 = 16'h0777; w0 = 1'b0; cs0 = 1'b1;
    bad = 0;
    repeat (CS_WAIT - 1) begin
      @(negedge clk);
      if (!o_rdy || o_st != 3'd0) bad++;
    end
    cs0 = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (!o_rdy || o_st != 3'd0 || o_ms) bad++;
    end
    chk("short_cs_no_sample", bad, 0);

    // Reset in the middle of a fill burst.
    a0 = 16'h4321; w0 = 1'b0; cs0 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (ms0 && as0 == 16'h432A) found = 1'b1;
    end
    chk("reached_fill_beat10", found, 1);
    rst = 1'b1; cs0 = 1'b0;
    @(negedge clk);
    chk("reset_mid_burst", {rdy0, st0, ms0, wen0}, {1'b1, 3'd0, 1'b0, 1'b0});
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    do_req(0, 16'h4321, 1'b0, 1'b0);

    // Randomised traffic on a few tags/sets to force hits, conflicts and evictions.
    repeat (40) begin
      logic [15:0] ra;
      ra = {8'($urandom_range(0, 5)), 3'($urandom_range(0, 1)), 5'($urandom)};
      do_req(0, ra, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    // Direct-mapped, zero-latency instance.
    do_req(1, 16'h1234, 1'b0, 1'b0);
    do_req(1, 16'h5634, 1'b0, 1'b0);
    repeat (20) begin
      logic [15:0] ra;
      ra = {8'($urandom_range(0, 3)), 3'($urandom_range(0, 1)), 5'($urandom)};
      do_req(1, ra, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
